video_timing_gen: RTL and testbench

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

---
 rtl/video_timing_gen.sv | 189 ++++++++++++++++++
 tb/tb_video_timing_gen.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Video timing generator: pixel-clock divider, raster position counters and
// registered sync/blank/strobe outputs.
// Optional build macro VTG_FRAME_CNT_EN enables the 16-bit completed-frame
// counter. Without it, frame_cnt is tied to zero and no counter flops exist.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | generator parked: divider cleared, outputs at (0,0), blanked
// S_RUN  | divider counting; each pixel tick presents the next position
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIX_DIV  = 4,
  parameter int COORD_W  = 10
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               run,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               hs,
  output logic               vs,
  output logic               blank,
  output logic               pix_ce,
  output logic               line_start,
  output logic               frame_start,
  output logic [15:0]        frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  typedef logic [COORD_W-1:0] coord_t;
  // One bit wider so thresholds equal to 2^COORD_W do not wrap to zero.
  typedef logic [COORD_W:0]   cmp_t;

  localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);
  localparam cmp_t   H_ACT  = cmp_t'(H_ACTIVE);
  localparam cmp_t   V_ACT  = cmp_t'(V_ACTIVE);
  localparam cmp_t   HS_BEG = cmp_t'(H_ACTIVE + H_FP);
  localparam cmp_t   HS_END = cmp_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam cmp_t   VS_BEG = cmp_t'(V_ACTIVE + V_FP);
  localparam cmp_t   VS_END = cmp_t'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [3:0] DIV_LAST = 4'(PIX_DIV - 1);
  localparam logic   HS_OFF = ~HS_POL;
  localparam logic   VS_OFF = ~VS_POL;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [1:0]  rst_sync_q;
  logic [3:0]  div_q, div_d;
  coord_t      hpos_q, hpos_d, vpos_q, vpos_d;
  coord_t      x_q, x_d, y_q, y_d;
  logic        hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
  logic        pix_ce_q, pix_ce_d, ls_q, ls_d, fs_q, fs_d;
  logic        run_ok, tick;
  cmp_t        hx, vy;

  // Reset release is re-timed through two flops before run is honoured.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rst_sync_q <= 2'b00;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign run_ok = run & rst_sync_q[1];
  assign tick   = run_ok && (div_q == DIV_LAST);
  assign hx     = cmp_t'(hpos_q);
  assign vy     = cmp_t'(vpos_q);

  // Next state, divider, position advance and next output values.
  always_comb begin
    state_d  = state_q;
    div_d    = '0;
    hpos_d   = hpos_q;
    vpos_d   = vpos_q;
    x_d      = x_q;
    y_d      = y_q;
    hs_d     = hs_q;
    vs_d     = vs_q;
    blank_d  = blank_q;
    pix_ce_d = 1'b0;
    ls_d     = 1'b0;
    fs_d     = 1'b0;
    case (state_q)
      S_IDLE:  if (run_ok)  state_d = S_RUN;
      S_RUN:   if (!run_ok) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_RUN) begin
      div_d    = (div_q == DIV_LAST) ? 4'd0 : div_q + 4'd1;
      pix_ce_d = (div_d == DIV_LAST);
      if (tick) begin
        x_d     = hpos_q;
        y_d     = vpos_q;
        hs_d    = (hx >= HS_BEG && hx < HS_END) ? HS_POL : HS_OFF;
        vs_d    = (vy >= VS_BEG && vy < VS_END) ? VS_POL : VS_OFF;
        blank_d = (hx >= H_ACT) || (vy >= V_ACT);
        ls_d    = (hpos_q == '0);
        fs_d    = (hpos_q == '0) && (vpos_q == '0);
        if (hpos_q == H_LAST) begin
          hpos_d = '0;
          vpos_d = (vpos_q == V_LAST) ? coord_t'(0) : vpos_q + coord_t'(1);
        end else begin
          hpos_d = hpos_q + coord_t'(1);
        end
      end
    end else begin
      // Abort or park: positions restart at the top-left pixel.
      hpos_d  = '0;
      vpos_d  = '0;
      x_d     = '0;
      y_d     = '0;
      hs_d    = HS_OFF;
      vs_d    = VS_OFF;
      blank_d = 1'b1;
    end
  end

  // State, divider, position and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      hpos_q   <= '0;
      vpos_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      hs_q     <= HS_OFF;
      vs_q     <= VS_OFF;
      blank_q  <= 1'b1;
      pix_ce_q <= 1'b0;
      ls_q     <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      hpos_q   <= hpos_d;
      vpos_q   <= vpos_d;
      x_q      <= x_d;
      y_q      <= y_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      blank_q  <= blank_d;
      pix_ce_q <= pix_ce_d;
      ls_q     <= ls_d;
      fs_q     <= fs_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign blank       = blank_q;
  assign pix_ce      = pix_ce_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

`ifdef VTG_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;
  logic        fc_inc;

  // A wrap is (0,0) being presented right after the last raster pixel, so the
  // first frame after leaving idle is not counted.
  assign fc_inc = tick && (hpos_q == '0) && (vpos_q == '0) &&
                  (x_q == H_LAST) && (y_q == V_LAST);

  // Completed-frame counter; holds while idle, cleared only by reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     frame_cnt_q <= 16'h0000;
    else if (fc_inc) frame_cnt_q <= frame_cnt_q + 16'd1;
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: two instances (divided pixel clock with
// active-low syncs, and undivided clock with active-high syncs), compared
// every cycle against a raster model computed from the elapsed run time.
module tb_video_timing_gen;

  typedef struct packed {
    int d; int ht; int vt; int hs0; int hs1; int vs0; int vs1; int ha; int va;
    bit hp; bit vp;
  } cfg_t;

  typedef struct packed {
    int x; int y; bit hs; bit vs; bit blank; bit ce; bit ls; bit fs;
  } exp_t;

  typedef struct {
    int j; int x; int y; bit hs; bit vs; bit blank; bit ls; bit fs; int fc;
  } vec_t;

  // A: PIX_DIV=3, H 8/2/3/2, V 5/1/2/1, active-low syncs.
  localparam cfg_t CFG_A = '{d:3, ht:15, vt:9, hs0:10, hs1:13, vs0:6, vs1:8,
                             ha:8, va:5, hp:1'b0, vp:1'b0};
  // B: PIX_DIV=1, H 8/1/2/1, V 4/1/1/1, active-high syncs.
  localparam cfg_t CFG_B = '{d:1, ht:12, vt:7, hs0:9, hs1:11, vs0:5, vs1:6,
                             ha:8, va:4, hp:1'b1, vp:1'b1};

  logic clk, resetn, run_a, run_b;
  logic [4:0]  xa, ya;
  logic [3:0]  xb, yb;
  logic hsa, vsa, bla, cea, lsa, fsa, hsb, vsb, blb, ceb, lsb, fsb;
  logic [15:0] fca_o, fcb_o;

  int checks = 0;
  int errors = 0;
  int na, nb, fca, fcb;
  bit chk_en;

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIX_DIV(3), .COORD_W(5)
  ) dut_a (
    .clk(clk), .resetn(resetn), .run(run_a), .x(xa), .y(ya), .hs(hsa), .vs(vsa),
    .blank(bla), .pix_ce(cea), .line_start(lsa), .frame_start(fsa), .frame_cnt(fca_o)
  );

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .PIX_DIV(1), .COORD_W(4)
  ) dut_b (
    .clk(clk), .resetn(resetn), .run(run_b), .x(xb), .y(yb), .hs(hsb), .vs(vsb),
    .blank(blb), .pix_ce(ceb), .line_start(lsb), .frame_start(fsb), .frame_cnt(fcb_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // n = consecutive clock edges at which run was sampled high.
  function automatic exp_t model(cfg_t c, int n);
    exp_t e;
    int k;
    e.x = 0; e.y = 0; e.hs = ~c.hp; e.vs = ~c.vp; e.blank = 1'b1;
    e.ls = 1'b0; e.fs = 1'b0;
    e.ce = (n >= 1) && (n % c.d == c.d - 1);
    if (n >= c.d) begin
      k       = n / c.d - 1;
      e.x     = k % c.ht;
      e.y     = (k / c.ht) % c.vt;
      e.hs    = (e.x >= c.hs0 && e.x < c.hs1) ? c.hp : ~c.hp;
      e.vs    = (e.y >= c.vs0 && e.y < c.vs1) ? c.vp : ~c.vp;
      e.blank = (e.x >= c.ha) || (e.y >= c.va);
      e.ls    = (n % c.d == 0) && (e.x == 0);
      e.fs    = e.ls && (e.y == 0);
    end
    return e;
  endfunction

  function automatic bit wrapped(cfg_t c, int n);
    int k;
    if (n < c.d || n % c.d != 0) return 1'b0;
    k = n / c.d - 1;
    return (k > 0) && (k % (c.ht * c.vt) == 0);
  endfunction

  function automatic int fc_exp(int m);
`ifdef VTG_FRAME_CNT_EN
    return m & 16'hFFFF;
`else
    return 0 & m;
`endif
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference time base.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      na = 0; nb = 0; fca = 0; fcb = 0;
    end else begin
      na = run_a ? na + 1 : 0;
      nb = run_b ? nb + 1 : 0;
      if (wrapped(CFG_A, na)) fca++;
      if (wrapped(CFG_B, nb)) fcb++;
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    exp_t ea, eb;
    if (chk_en) begin
      ea = model(CFG_A, na);
      eb = model(CFG_B, nb);
      check("a_x", int'(xa), ea.x);      check("a_y", int'(ya), ea.y);
      check("a_hs", int'(hsa), int'(ea.hs)); check("a_vs", int'(vsa), int'(ea.vs));
      check("a_blank", int'(bla), int'(ea.blank)); check("a_pix_ce", int'(cea), int'(ea.ce));
      check("a_line_start", int'(lsa), int'(ea.ls)); check("a_frame_start", int'(fsa), int'(ea.fs));
      check("a_frame_cnt", int'(fca_o), fc_exp(fca));
      check("b_x", int'(xb), eb.x);      check("b_y", int'(yb), eb.y);
      check("b_hs", int'(hsb), int'(eb.hs)); check("b_vs", int'(vsb), int'(eb.vs));
      check("b_blank", int'(blb), int'(eb.blank)); check("b_pix_ce", int'(ceb), int'(eb.ce));
      check("b_line_start", int'(lsb), int'(eb.ls)); check("b_frame_start", int'(fsb), int'(eb.fs));
      check("b_frame_cnt", int'(fcb_o), fc_exp(fcb));
    end
  end

  vec_t vec[14];

  initial begin
    int cur, cyc, t0, t1, cnt;
    bit found;

    // j = cycles after the first run=1 cycle on instance B.
    vec[0]  = '{0,  0, 0, 0, 0, 1, 0, 0, 0};
    vec[1]  = '{1,  0, 0, 0, 0, 0, 1, 1, 0};
    vec[2]  = '{8,  7, 0, 0, 0, 0, 0, 0, 0};
    vec[3]  = '{9,  8, 0, 0, 0, 1, 0, 0, 0};
    vec[4]  = '{10, 9, 0, 1, 0, 1, 0, 0, 0};
    vec[5]  = '{11, 10, 0, 1, 0, 1, 0, 0, 0};
    vec[6]  = '{12, 11, 0, 0, 0, 1, 0, 0, 0};
    vec[7]  = '{13, 0, 1, 0, 0, 0, 1, 0, 0};
    vec[8]  = '{49, 0, 4, 0, 0, 1, 1, 0, 0};
    vec[9]  = '{61, 0, 5, 0, 1, 1, 1, 0, 0};
    vec[10] = '{72, 11, 5, 0, 1, 1, 0, 0, 0};
    vec[11] = '{73, 0, 6, 0, 0, 1, 1, 0, 0};
    vec[12] = '{84, 11, 6, 0, 0, 1, 0, 0, 0};
    vec[13] = '{85, 0, 0, 0, 0, 0, 1, 1, 1};

    resetn = 1'b1; run_a = 1'b0; run_b = 1'b0; chk_en = 1'b0;
    #2 resetn = 1'b0;
    #1 chk_en = 1'b1;
    @(posedge clk); @(posedge clk); #1 resetn = 1'b1;
    repeat (3) @(posedge clk);
    #1 run_a = 1'b1; run_b = 1'b1;

    cur = 0;
    @(negedge clk);
    for (int i = 0; i < 14; i++) begin
      while (cur < vec[i].j) begin @(negedge clk); cur++; end
      check($sformatf("tbl%0d_x", i), int'(xb), vec[i].x);
      check($sformatf("tbl%0d_y", i), int'(yb), vec[i].y);
      check($sformatf("tbl%0d_hs", i), int'(hsb), int'(vec[i].hs));
      check($sformatf("tbl%0d_vs", i), int'(vsb), int'(vec[i].vs));
      check($sformatf("tbl%0d_blank", i), int'(blb), int'(vec[i].blank));
      check($sformatf("tbl%0d_ls", i), int'(lsb), int'(vec[i].ls));
      check($sformatf("tbl%0d_fs", i), int'(fsb), int'(vec[i].fs));
      check($sformatf("tbl%0d_fc", i), int'(fcb_o), fc_exp(vec[i].fc));
    end

    // Frame and line periods, sync width and pix_ce duty on instance B.
    cyc = 0;
    @(negedge clk); cyc++;
    while (!fsb && cyc < 200) begin @(negedge clk); cyc++; end
    t0 = cyc;
    @(negedge clk); cyc++;
    while (!fsb && cyc < 400) begin @(negedge clk); cyc++; end
    t1 = cyc;
    check("b_frame_period", t1 - t0, 84);
    cyc = 0;
    @(negedge clk); cyc++;
    while (!lsb && cyc < 50) begin @(negedge clk); cyc++; end
    t0 = cyc; cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (hsb) cnt++;
      @(negedge clk); cyc++;
    end
    check("b_hs_width", cnt, 2);
    while (!lsb && cyc < 100) begin @(negedge clk); cyc++; end
    check("b_line_period", cyc - t0, 12);
    cnt = 0;
    for (int i = 0; i < 84; i++) begin
      if (ceb) cnt++;
      @(negedge clk);
    end
    check("b_pix_ce_duty", cnt, 84);

    // Mid-line abort on instance A at (5,3), then restart.
    found = 1'b0; cyc = 0;
    while (!found && cyc < 2000) begin
      @(negedge clk); cyc++;
      found = (xa == 5'd5) && (ya == 5'd3);
    end
    check("a_abort_found", int'(found), 1);
    run_a = 1'b0;
    @(negedge clk);
    check("a_abort_x", int'(xa), 0);   check("a_abort_y", int'(ya), 0);
    check("a_abort_blank", int'(bla), 1); check("a_abort_hs", int'(hsa), 1);
    check("a_abort_vs", int'(vsa), 1);
    run_a = 1'b1;
    repeat (3) @(negedge clk);
    check("a_restart_fs", int'(fsa), 1); check("a_restart_x", int'(xa), 0);
    check("a_restart_y", int'(ya), 0);   check("a_restart_blank", int'(bla), 0);

    // Random run toggling on both instances.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (run_a) run_a = ($urandom_range(0, 299) != 0);
      else       run_a = ($urandom_range(0, 2) == 0);
      if (run_b) run_b = ($urandom_range(0, 149) != 0);
      else       run_b = ($urandom_range(0, 2) == 0);
    end

    // Several full frames of both, then an asynchronous reset pulse mid-frame.
    @(posedge clk); #1 run_a = 1'b1; run_b = 1'b1;
    repeat (1300) @(posedge clk);
    #1 resetn = 1'b0;
    #2;
    check("rst_a_x", int'(xa), 0);  check("rst_a_blank", int'(bla), 1);
    check("rst_a_fc", int'(fca_o), 0);
    check("rst_b_y", int'(yb), 0);  check("rst_b_hs", int'(hsb), 0);
    check("rst_b_fc", int'(fcb_o), 0);
    run_a = 1'b0; run_b = 1'b0;
    @(posedge clk); #1 resetn = 1'b1;
    repeat (3) @(posedge clk);
    #1 run_a = 1'b1; run_b = 1'b1;
    repeat (200) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
